wb_bus_arbiter: RTL and testbench
=================================

// Module: wb_bus_arbiter
// PURPOSE
//  Two-master, one-slave Wishbone B4 (classic) arbiter. Shares the single memory port between the
//  fetch stage (M0, instruction reads) and the memory stage (M1, loads/stores).
//  Round-robin grant; the grant is held for a whole bus cycle (cyc high).
//  Sits between the pipeline stages and the memory/interconnect slave.
// PARAMETERS
//  ADDR_W          32   address width, all ports
//  DATA_W          32   data width; SEL_W = DATA_W/8
//  TIMEOUT_CYCLES  255  stall limit in cycles, only used when WB_ARB_TIMEOUT_EN is defined; must be >= 1
// PORTS
//  clk          in   1       single clock, rising edge
//  rst          in   1       synchronous, active-low reset
//  m0_cyc/m0_stb/m0_we  in  1  fetch master cycle/strobe/write-enable
//  m0_sel       in   SEL_W   fetch master byte select
//  m0_adr       in   ADDR_W  fetch master address
//  m0_dat_mosi  in   DATA_W  fetch master write data
//  m0_ack/m0_err  out  1     fetch master terminations
//  m0_dat_miso  out  DATA_W  fetch master read data
//  m1_*         same set as m0_*, for the memory-stage master
//  s_cyc/s_stb/s_we  out  1  slave cycle/strobe/write-enable
//  s_sel        out  SEL_W   slave byte select
//  s_adr        out  ADDR_W  slave address
//  s_dat_mosi   out  DATA_W  slave write data
//  s_ack/s_err  in   1       slave terminations
//  s_dat_miso   in   DATA_W  slave read data
//  grant_out    out  2       one-hot current owner {M1,M0}, 00 = none
// BEHAVIOUR
//  - Reset (rst==0 at a clk edge): state IDLE, grant_out=00, last_owner=M1 so M0 wins the first tie.
//    All s_* outputs and m*_ack/m*_err are 0. A transfer in flight at reset is dropped; no ack reaches the master.
//  - FSM states: IDLE, GNT0, GNT1 (+ ABORT with the macro). grant_out is registered and decoded from the state.
//  - IDLE: m0_cyc only -> GNT0. m1_cyc only -> GNT1. Both -> the master that is not last_owner.
//    The grant takes effect at the next edge: a request seen in cycle n gives s_cyc in cycle n+1.
//  - GNTx: the s_* request signals are combinationally routed from master x; the other master's
//    request is ignored. The s_* request signals are forced to 0 whenever grant_out==00.
//  - s_ack/s_err are routed only to the granted master. The ungranted master's ack/err are always 0.
//  - s_dat_miso is broadcast to m0_dat_miso and m1_dat_miso; a master qualifies it with its own ack.
//  - Leaving GNTx: when mx_cyc==0 at an edge -> IDLE and last_owner<=x. This gives a 1-cycle gap
//    between owners. Back-to-back transfers under continuous cyc stay locked to x (bus lock for RMW).
//  - Simultaneous events: cyc drop and a new request in the same cycle -> IDLE, then arbitration
//    next cycle (not same-cycle handover).
//  - No buffering: ack/err pass through combinationally; arbiter adds zero latency once granted.
// CONFIGURATION
//  - WB_ARB_TIMEOUT_EN defined: a counter (width $clog2(TIMEOUT_CYCLES+1)) increments each GNTx cycle
//    with s_stb=1 and s_ack=s_err=0. It clears on ack, on err, or on leaving GNTx.
//    When it reaches TIMEOUT_CYCLES -> ABORT for exactly one cycle: s_cyc=s_stb=0,
//    mx_err=1, mx_ack=0. Then IDLE, last_owner<=x. A slave ack arriving in the ABORT cycle is discarded.
//  - Not defined: no counter, no ABORT state. A stalled slave holds the grant indefinitely.
// STRUCTURE
//  - wb_arb_pkg: typedef enum logic[1:0] arb_state_t {IDLE,GNT0,GNT1,ABORT};
//    typedef enum logic owner_t {OWN_M0,OWN_M1}; localparam GRANT_NONE=2'b00.
//  - Sub-module wb_arb_watchdog (counter + expiry pulse), instantiated only under WB_ARB_TIMEOUT_EN.
//  - Top holds FSM, last_owner, and the output muxes.
// TESTING
//  1 Reset: rst=0 for 2 cycles while m0_cyc=m1_cyc=1 -> all s_*=0, grant_out=00; first cycle after
//    release is IDLE; next cycle grant_out=01.
//  2 Single M0 read: adr=0x0000_0100, slave acks 2 cycles after s_stb with 0xDEADBEEF
//    -> m0_ack for 1 cycle, m0_dat_miso=0xDEADBEEF, m1_ack stays 0.
//  3 Tie: m0 and m1 request in the same cycle, 3 rounds -> grant sequence M0,M1,M0,
//    1 idle cycle between owners.
//  4 Lock: M1 holds cyc over 4 transfers while M0 requests -> M0 not granted until M1 drops cyc,
//    then granted 2 cycles later.
//  5 Mid-op reset: rst=0 while in GNT1 with stb pending -> s_cyc=0 next cycle, no m1_ack, grant_out=00.
//  6 (WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8) slave never acks M0 -> m0_err pulses 1 cycle
//    8 cycles after s_stb first high; s_cyc=0 in that cycle; pending M1 granted afterwards.

Source files
------------

// File: rtl/wb_bus_arbiter_pkg.sv
// wb_arb_pkg: shared state/owner types for the two-master Wishbone arbiter
package wb_arb_pkg;
  typedef enum logic [1:0] {IDLE, GNT0, GNT1, ABORT} arb_state_t;
  typedef enum logic {OWN_M0, OWN_M1} owner_t;
  localparam logic [1:0] GRANT_NONE = 2'b00;
endpackage

// File: rtl/wb_bus_arbiter_if.sv
// wb_bus_arbiter_if: one Wishbone B4 classic port; master drives the request, slave drives the termination
interface wb_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int SEL_W = DATA_W / 8;
  logic              cyc;
  logic              stb;
  logic              we;
  logic [SEL_W-1:0]  sel;
  logic [ADDR_W-1:0] adr;
  logic [DATA_W-1:0] dat_mosi;
  logic              ack;
  logic              err;
  logic [DATA_W-1:0] dat_miso;
  modport master (output cyc, stb, we, sel, adr, dat_mosi, input ack, err, dat_miso);
  modport slave  (input cyc, stb, we, sel, adr, dat_mosi, output ack, err, dat_miso);
endinterface

// File: rtl/wb_bus_arbiter_watchdog.sv
// wb_arb_watchdog: stall counter for WB_ARB_TIMEOUT_EN builds; expire_o flags the cycle the count reaches TIMEOUT_CYCLES
module wb_arb_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic active_i,
  input  logic stall_i,
  input  logic clear_i,
  output logic expire_o
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d    = (!active_i || clear_i) ? '0 : stall_i ? cnt_q + CW'(1) : cnt_q;
    expire_o = active_i && stall_i && !clear_i && (cnt_d == CW'(TIMEOUT_CYCLES));
  end
  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
endmodule

// File: rtl/wb_bus_arbiter.sv
// wb_bus_arbiter: round-robin two-master Wishbone arbiter with bus lock; WB_ARB_TIMEOUT_EN adds a stall watchdog
module wb_bus_arbiter
  import wb_arb_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst,
  wb_bus_arbiter_if.slave  m0,
  wb_bus_arbiter_if.slave  m1,
  wb_bus_arbiter_if.master s,
  output logic [1:0]       grant_out
);
  localparam int SEL_W = DATA_W / 8;
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be >= 1");
  end
  arb_state_t state_q, state_d;
  owner_t last_owner_q, last_owner_d;
  logic g0, g1, ab, wd_expire;
  logic [ADDR_W-1:0] adr_mux;
  logic [SEL_W-1:0] sel_mux;
  logic [DATA_W-1:0] dat_mux;
`ifdef WB_ARB_TIMEOUT_EN
  wb_arb_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .active_i (g0 || g1),
    .stall_i  (s.stb),
    .clear_i  (s.ack || s.err),
    .expire_o (wd_expire)
  );
`else
  assign wd_expire = 1'b0;
`endif
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    unique case (state_q)
      IDLE: state_d = (m0.cyc && (!m1.cyc || last_owner_q == OWN_M1)) ? GNT0 : m1.cyc ? GNT1 : IDLE;
      GNT0: if (!m0.cyc || wd_expire) begin
        state_d      = m0.cyc ? ABORT : IDLE;
        last_owner_d = OWN_M0;
      end
      GNT1: if (!m1.cyc || wd_expire) begin
        state_d      = m1.cyc ? ABORT : IDLE;
        last_owner_d = OWN_M1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    g0         = state_q == GNT0;
    g1         = state_q == GNT1;
    ab         = state_q == ABORT;
    grant_out  = g0 ? 2'b01 : g1 ? 2'b10 : GRANT_NONE;
    adr_mux    = g0 ? m0.adr : g1 ? m1.adr : '0;
    sel_mux    = g0 ? m0.sel : g1 ? m1.sel : '0;
    dat_mux    = g0 ? m0.dat_mosi : g1 ? m1.dat_mosi : '0;
    s.cyc      = g0 ? m0.cyc : g1 && m1.cyc;
    s.stb      = g0 ? m0.stb : g1 && m1.stb;
    s.we       = g0 ? m0.we : g1 && m1.we;
    s.adr      = adr_mux;
    s.sel      = sel_mux;
    s.dat_mosi = dat_mux;
    // during ABORT last_owner already names the aborted master
    m0.ack      = g0 && s.ack;
    m1.ack      = g1 && s.ack;
    m0.err      = (g0 && s.err) || (ab && last_owner_q == OWN_M0);
    m1.err      = (g1 && s.err) || (ab && last_owner_q == OWN_M1);
    m0.dat_miso = s.dat_miso;
    m1.dat_miso = s.dat_miso;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_owner_q <= OWN_M1;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
    end
  end
endmodule

// File: tb/tb_wb_bus_arbiter.sv
// tb_wb_bus_arbiter: table-driven cycle vectors plus stall/timeout sequences for wb_bus_arbiter
module tb_wb_bus_arbiter;
  localparam logic [31:0] A = 32'h0000_0100;
  localparam logic [31:0] B = 32'h0000_0200;
  logic clk = 1'b0;
  logic rst;
  logic [1:0] grant_out;
  int n_chk = 0;
  int n_fail = 0;
  wb_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m0_if ();
  wb_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m1_if ();
  wb_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) s_if ();
  wb_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .m0        (m0_if),
    .m1        (m1_if),
    .s         (s_if),
    .grant_out (grant_out)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic rst;
    logic c0, s0, w0;
    logic c1, s1, w1;
    logic sack, serr;
    logic [31:0] sdat;
    logic [1:0] g;
    logic scyc, sstb, swe;
    logic [31:0] sadr;
    logic ack0, err0, ack1, err1;
  } vec_t;
  vec_t tbl [27];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic apply(input vec_t v);
    rst = v.rst;
    m0_if.cyc = v.c0; m0_if.stb = v.s0; m0_if.we = v.w0;
    m1_if.cyc = v.c1; m1_if.stb = v.s1; m1_if.we = v.w1;
    s_if.ack = v.sack; s_if.err = v.serr; s_if.dat_miso = v.sdat;
  endtask
  task automatic drive_idle();
    rst = 1'b1;
    m0_if.cyc = 1'b0; m0_if.stb = 1'b0; m0_if.we = 1'b0;
    m1_if.cyc = 1'b0; m1_if.stb = 1'b0; m1_if.we = 1'b0;
    s_if.ack = 1'b0; s_if.err = 1'b0; s_if.dat_miso = '0;
  endtask
  initial begin
    int hold, errs, k, stb_at, err_at;
    m0_if.adr = A; m0_if.sel = 4'hF; m0_if.dat_mosi = 32'hAAAA_0000;
    m1_if.adr = B; m1_if.sel = 4'h3; m1_if.dat_mosi = 32'hBBBB_0000;
    //          rst c0 s0 w0 c1 s1 w1 ack err sdat           g      cyc stb we adr ack0 err0 ack1 err1
    tbl[0]  = '{0, 1, 1, 0, 1, 1, 0, 0, 0, 32'h0,          2'b00, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 1, 1, 0, 1, 1, 0, 0, 0, 32'h0,          2'b00, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{1, 1, 1, 0, 1, 1, 0, 0, 0, 32'h0,          2'b01, 1, 1, 0, A, 0, 0, 0, 0};
    tbl[3]  = '{1, 1, 1, 0, 1, 1, 0, 0, 0, 32'h0,          2'b01, 1, 1, 0, A, 0, 0, 0, 0};
    tbl[4]  = '{1, 1, 1, 0, 1, 1, 0, 1, 0, 32'hDEADBEEF,   2'b01, 1, 1, 0, A, 1, 0, 0, 0};
    tbl[5]  = '{1, 0, 0, 0, 1, 1, 0, 0, 0, 32'h0,          2'b01, 0, 0, 0, A, 0, 0, 0, 0};
    tbl[6]  = '{1, 1, 1, 0, 1, 1, 0, 0, 0, 32'h0,          2'b00, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[7]  = '{1, 1, 1, 0, 1, 1, 0, 1, 0, 32'h12345678,   2'b10, 1, 1, 0, B, 0, 0, 1, 0};
    tbl[8]  = '{1, 1, 1, 0, 0, 0, 0, 0, 0, 32'h0,          2'b10, 0, 0, 0, B, 0, 0, 0, 0};
    tbl[9]  = '{1, 1, 1, 0, 1, 1, 0, 0, 0, 32'h0,          2'b00, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[10] = '{1, 1, 1, 0, 1, 1, 0, 1, 0, 32'hCAFEF00D,   2'b01, 1, 1, 0, A, 1, 0, 0, 0};
    tbl[11] = '{1, 0, 0, 0, 1, 1, 0, 0, 0, 32'h0,          2'b01, 0, 0, 0, A, 0, 0, 0, 0};
    tbl[12] = '{1, 1, 1, 0, 1, 1, 0, 0, 0, 32'h0,          2'b00, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[13] = '{1, 1, 1, 0, 1, 1, 0, 1, 0, 32'h11111111,   2'b10, 1, 1, 0, B, 0, 0, 1, 0};
    tbl[14] = '{1, 1, 1, 0, 1, 1, 0, 1, 0, 32'h22222222,   2'b10, 1, 1, 0, B, 0, 0, 1, 0};
    tbl[15] = '{1, 1, 1, 0, 1, 0, 0, 0, 0, 32'h0,          2'b10, 1, 0, 0, B, 0, 0, 0, 0};
    tbl[16] = '{1, 1, 1, 0, 1, 1, 1, 1, 0, 32'h33333333,   2'b10, 1, 1, 1, B, 0, 0, 1, 0};
    tbl[17] = '{1, 1, 1, 0, 1, 1, 0, 0, 1, 32'h0,          2'b10, 1, 1, 0, B, 0, 0, 0, 1};
    tbl[18] = '{1, 1, 1, 0, 0, 0, 0, 0, 0, 32'h0,          2'b10, 0, 0, 0, B, 0, 0, 0, 0};
    tbl[19] = '{1, 1, 1, 0, 0, 0, 0, 0, 0, 32'h0,          2'b00, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[20] = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 32'h0,          2'b01, 1, 1, 1, A, 0, 0, 0, 0};
    tbl[21] = '{1, 0, 0, 0, 1, 1, 0, 0, 0, 32'h0,          2'b01, 0, 0, 0, A, 0, 0, 0, 0};
    tbl[22] = '{1, 0, 0, 0, 1, 1, 0, 0, 0, 32'h0,          2'b00, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[23] = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 32'h0,          2'b10, 1, 1, 0, B, 0, 0, 0, 0};
    tbl[24] = '{1, 0, 0, 0, 1, 1, 0, 1, 0, 32'h44444444,   2'b00, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[25] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,          2'b10, 0, 0, 0, B, 0, 0, 0, 0};
    tbl[26] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,          2'b00, 0, 0, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 27; i++) begin
      apply(tbl[i]);
      @(negedge clk);
      chk($sformatf("v%0d grant_out", i), 32'(grant_out), 32'(tbl[i].g));
      chk($sformatf("v%0d s_cyc", i), 32'(s_if.cyc), 32'(tbl[i].scyc));
      chk($sformatf("v%0d s_stb", i), 32'(s_if.stb), 32'(tbl[i].sstb));
      chk($sformatf("v%0d s_we", i), 32'(s_if.we), 32'(tbl[i].swe));
      chk($sformatf("v%0d s_adr", i), s_if.adr, tbl[i].sadr);
      chk($sformatf("v%0d m0_ack", i), 32'(m0_if.ack), 32'(tbl[i].ack0));
      chk($sformatf("v%0d m0_err", i), 32'(m0_if.err), 32'(tbl[i].err0));
      chk($sformatf("v%0d m1_ack", i), 32'(m1_if.ack), 32'(tbl[i].ack1));
      chk($sformatf("v%0d m1_err", i), 32'(m1_if.err), 32'(tbl[i].err1));
      chk($sformatf("v%0d m0_dat_miso", i), m0_if.dat_miso, tbl[i].sdat);
      chk($sformatf("v%0d m1_dat_miso", i), m1_if.dat_miso, tbl[i].sdat);
      @(posedge clk); #1;
    end
    drive_idle();
    m0_if.cyc = 1'b1; m0_if.stb = 1'b1;
`ifdef WB_ARB_TIMEOUT_EN
    stb_at = -1; err_at = -1;
    for (k = 0; k < 40 && err_at < 0; k++) begin
      @(negedge clk);
      if (stb_at < 0 && s_if.stb && grant_out == 2'b01) begin
        stb_at = k;
        m1_if.cyc = 1'b1; m1_if.stb = 1'b1;
      end
      if (m0_if.err) begin
        err_at = k;
        chk("abort s_cyc", 32'(s_if.cyc), 32'd0);
        chk("abort s_stb", 32'(s_if.stb), 32'd0);
        chk("abort m0_ack", 32'(m0_if.ack), 32'd0);
        chk("abort m1_err", 32'(m1_if.err), 32'd0);
      end
    end
    chk("timeout latency", 32'(err_at - stb_at), 32'd8);
    chk("timeout seen", 32'(err_at >= 0), 32'd1);
    @(negedge clk);
    chk("post-abort m0_err", 32'(m0_if.err), 32'd0);
    chk("post-abort grant", 32'(grant_out), 32'd0);
    @(negedge clk);
    chk("pending m1 grant", 32'(grant_out), 32'b10);
`else
    hold = 0; errs = 0;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (grant_out == 2'b01 && s_if.stb) hold++;
      if (m0_if.err || m1_if.err) errs++;
    end
    chk("stall hold cycles", 32'(hold), 32'd19);
    chk("stall err cycles", 32'(errs), 32'd0);
    @(posedge clk); #1;
    m1_if.cyc = 1'b1; m1_if.stb = 1'b1;
    @(negedge clk);
    chk("stall locked vs m1", 32'(grant_out), 32'b01);
`endif
    @(posedge clk); #1;
    drive_idle();
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("final idle grant", 32'(grant_out), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
